// File: rtl/irq_arbiter_pkg.sv
// Shared constants, register map, FSM states and priority encoder for irq_arbiter.
package irq_arbiter_pkg;

  localparam int unsigned IRQ_N_DEFAULT = 8;
  localparam int unsigned VEC_W         = 3;

  typedef enum logic [1:0] {
    REG_MASK = 2'd0,
    REG_MODE = 2'd1,
    REG_POL  = 2'd2,
    REG_PEND = 2'd3
  } reg_addr_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_e;

  // Lowest set index wins; scanning downward lets the lowest index overwrite last.
  function automatic logic [VEC_W-1:0] prio_enc(input logic [7:0] c);
    logic [VEC_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[7-i]) v = VEC_W'(7 - i);
    end
    return v;
  endfunction

endpackage

// File: rtl/irq_arbiter_edge_sync.sv
// Three-flop synchronizer for one interrupt line with polarity/mode hit detection.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_src,
  input  logic i_mode,
  input  logic i_pol,
  output logic o_hit
);

  logic r_s0, r_s1, r_s2;

  // Flops reset high so an idle, pulled-up line produces no spurious edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s0 <= i_src;
      r_s1 <= r_s0;
      r_s2 <= r_s1;
    end
  end

  always_comb begin
    if (i_mode) o_hit = i_pol ? r_s1 : ~r_s1;
    else        o_hit = i_pol ? (r_s1 & ~r_s2) : (~r_s1 & r_s2);
  end

endmodule

// File: rtl/irq_arbiter.sv
// Eight-source interrupt controller: pending/mask registers, priority encoder and ack/eoi FSM.
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int unsigned N = IRQ_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] src,
  input  logic         we,
  input  logic [1:0]   addr,
  input  logic [N-1:0] wdata,
  output logic [N-1:0] rdata,
  output logic         irq_n,
  output logic [2:0]   vec,
  input  logic         ack,
  input  logic         eoi
);

  logic [N-1:0] r_mask, r_mode, r_pol, r_pend;
  logic [N-1:0] w_hit, w_cand, w_w1c, w_ack_clr, w_pend_nxt;
  logic [7:0]   w_cand8;
  logic [2:0]   w_top;
  logic         w_ack_req;
  logic         w_wr_mask, w_wr_mode, w_wr_pol, w_wr_pend;

  state_e       r_state;
  logic         r_irq_n;
  logic [2:0]   r_vec;

  for (genvar g = 0; g < N; g++) begin : g_sync
    edge_sync u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_src  (src[g]),
      .i_mode (r_mode[g]),
      .i_pol  (r_pol[g]),
      .o_hit  (w_hit[g])
    );
  end

  always_comb begin
    w_wr_mask = we && (addr == REG_MASK);
    w_wr_mode = we && (addr == REG_MODE);
    w_wr_pol  = we && (addr == REG_POL);
    w_wr_pend = we && (addr == REG_PEND);
    w_ack_req = ack && (r_state == ST_REQ);
    w_cand    = r_pend & r_mask;
    w_cand8   = '0;
    w_cand8[N-1:0] = w_cand;
    w_top     = prio_enc(w_cand8);
    w_w1c     = w_wr_pend ? wdata : '0;
  end

  // Edge-mode bits: set wins over ack/W1C clear; level-mode bits just mirror the hit.
  always_comb begin
    w_ack_clr  = '0;
    w_pend_nxt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_ack_clr[i]  = w_ack_req && (r_vec == 3'(i));
      w_pend_nxt[i] = r_mode[i] ? w_hit[i]
                    : (w_hit[i] | (r_pend[i] & ~(w_w1c[i] | w_ack_clr[i])));
    end
  end

  always_comb begin
    case (addr)
      REG_MASK: rdata = r_mask;
      REG_MODE: rdata = r_mode;
      REG_POL:  rdata = r_pol;
      default:  rdata = r_pend;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '0;
      r_mode <= '0;
      r_pol  <= '0;
      r_pend <= '0;
    end else begin
      if (w_wr_mask) r_mask <= wdata;
      if (w_wr_mode) r_mode <= wdata;
      if (w_wr_pol)  r_pol  <= wdata;
      r_pend <= w_pend_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_irq_n <= 1'b1;
      r_vec   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_cand) begin
            r_state <= ST_REQ;
            r_irq_n <= 1'b0;
            r_vec   <= w_top;
          end
        end
        ST_REQ: begin
          if (ack) begin
            r_state <= ST_SVC;
            r_irq_n <= 1'b1;
          end else if (~|w_cand) begin
            r_state <= ST_IDLE;
            r_irq_n <= 1'b1;
          end else begin
            r_vec <= w_top;
          end
        end
        ST_SVC: begin
          if (eoi) r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_irq_n <= 1'b1;
        end
      endcase
    end
  end

  assign irq_n = r_irq_n;
  assign vec   = r_vec;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed and randomized bench for irq_arbiter against a cycle-level behavioural model.
module tb_irq_arbiter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] src;
  logic         we;
  logic [1:0]   addr;
  logic [N-1:0] wdata;
  logic [N-1:0] rdata;
  logic         irq_n;
  logic [2:0]   vec;
  logic         ack;
  logic         eoi;

  int checks = 0;
  int errors = 0;

  irq_arbiter #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .src   (src),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq_n (irq_n),
    .vec   (vec),
    .ack   (ack),
    .eoi   (eoi)
  );

  always #5 clk = ~clk;

  // Reference model: sample history, registers, and service state (0 idle, 1 requesting, 2 servicing).
  logic [N-1:0] m_mask, m_mode, m_pol, m_pend;
  logic [N-1:0] m_smp [3];
  int           m_st;
  logic         m_irq_n;
  int           m_vec;

  function automatic int lowest(input logic [N-1:0] c);
    int r;
    r = -1;
    for (int i = N - 1; i >= 0; i--) if (c[i]) r = i;
    return r;
  endfunction

  function automatic logic [N-1:0] m_rd(input logic [1:0] a);
    case (a)
      2'd0:    return m_mask;
      2'd1:    return m_mode;
      2'd2:    return m_pol;
      default: return m_pend;
    endcase
  endfunction

  task automatic model_reset();
    m_mask = '0; m_mode = '0; m_pol = '0; m_pend = '0;
    for (int i = 0; i < 3; i++) m_smp[i] = '1;
    m_st = 0; m_irq_n = 1'b1; m_vec = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] hit, clr, npend, s1, s2;
    int top;
    s1 = m_smp[1];
    s2 = m_smp[2];
    for (int i = 0; i < N; i++) begin
      if (m_mode[i]) hit[i] = m_pol[i] ? s1[i] : !s1[i];
      else           hit[i] = m_pol[i] ? (s1[i] && !s2[i]) : (!s1[i] && s2[i]);
    end
    top = lowest(m_pend & m_mask);
    clr = (we && addr == 2'd3) ? wdata : '0;
    if (m_st == 1 && ack) clr[m_vec] = 1'b1;
    for (int i = 0; i < N; i++)
      npend[i] = m_mode[i] ? hit[i] : (hit[i] || (m_pend[i] && !clr[i]));
    if (m_st == 0) begin
      if (top >= 0) begin m_st = 1; m_irq_n = 1'b0; m_vec = top; end
    end else if (m_st == 1) begin
      if (ack)           begin m_st = 2; m_irq_n = 1'b1; end
      else if (top < 0)  begin m_st = 0; m_irq_n = 1'b1; end
      else               m_vec = top;
    end else if (eoi) begin
      m_st = 0;
    end
    if (we && addr == 2'd0) m_mask = wdata;
    if (we && addr == 2'd1) m_mode = wdata;
    if (we && addr == 2'd2) m_pol  = wdata;
    m_pend   = npend;
    m_smp[2] = m_smp[1];
    m_smp[1] = m_smp[0];
    m_smp[0] = src;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("m_irq_n", 32'(irq_n), 32'(m_irq_n));
    chk("m_vec",   32'(vec),   32'(m_vec));
    chk("m_rdata", 32'(rdata), 32'(m_rd(addr)));
  endtask

  task automatic wr(input logic [1:0] a, input logic [N-1:0] d);
    we = 1'b1; addr = a; wdata = d;
    cycle();
    we = 1'b0; addr = 2'd3; wdata = '0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1; cycle(); ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; cycle(); eoi = 1'b0;
  endtask

  task automatic wait_irq();
    int n;
    n = 0;
    while (irq_n !== 1'b0 && n < 20) begin
      cycle();
      n++;
    end
    chk("wait_irq", 32'(irq_n), 32'd0);
  endtask

  task automatic do_reset();
    we = 1'b0; ack = 1'b0; eoi = 1'b0; wdata = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_irq_n", 32'(irq_n), 32'd1);
    chk("rst_vec",   32'(vec),   32'd0);
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      chk("rst_rdata", 32'(rdata), 32'd0);
    end
    addr = 2'd3;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; src = '1; we = 1'b0; addr = 2'd3; wdata = '0; ack = 1'b0; eoi = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single falling edge on source 3
    wr(2'd0, 8'hFF); wr(2'd1, 8'h00); wr(2'd2, 8'h00);
    src = 8'hF7;
    cycle(); cycle();
    chk("t1_pend_k1", 32'(rdata), 32'h00);
    cycle();
    chk("t1_pend_k2", 32'(rdata), 32'h08);
    chk("t1_irq_k2",  32'(irq_n), 32'd1);
    cycle();
    chk("t1_irq_k3",  32'(irq_n), 32'd0);
    chk("t1_vec_k3",  32'(vec),   32'd3);
    pulse_ack();
    chk("t1_pend_ack", 32'(rdata), 32'h00);
    chk("t1_irq_ack",  32'(irq_n), 32'd1);
    src = 8'hFF;
    pulse_eoi();
    chk("t1_irq_eoi", 32'(irq_n), 32'd1);
    repeat (3) cycle();

    // Simultaneous sources 5 and 2
    src = 8'hDB;
    repeat (4) cycle();
    chk("t2_irq", 32'(irq_n), 32'd0);
    chk("t2_vec", 32'(vec),   32'd2);
    pulse_ack();
    pulse_eoi();
    chk("t2_gap", 32'(irq_n), 32'd1);
    cycle();
    chk("t2_irq5", 32'(irq_n), 32'd0);
    chk("t2_vec5", 32'(vec),   32'd5);
    pulse_ack();
    pulse_eoi();
    src = 8'hFF;
    repeat (3) cycle();

    // Level-high source 1 re-requests until released
    wr(2'd1, 8'h02); wr(2'd2, 8'h02);
    for (int r = 0; r < 3; r++) begin
      wait_irq();
      chk("t3_vec", 32'(vec), 32'd1);
      pulse_ack();
      if (r == 2) src = 8'hFD;
      repeat (4) cycle();
      pulse_eoi();
    end
    repeat (3) cycle();
    chk("t3_pend1", 32'(rdata[1]), 32'd0);
    chk("t3_idle",  32'(irq_n),    32'd1);
    wr(2'd1, 8'h00); wr(2'd2, 8'h00);
    src = 8'hFF;
    repeat (3) cycle();

    // Masking while requesting
    src = 8'hEF;
    wait_irq();
    chk("t4_vec", 32'(vec), 32'd4);
    wr(2'd0, 8'h00);
    cycle();
    chk("t4_irq_masked", 32'(irq_n),    32'd1);
    chk("t4_pend4",      32'(rdata[4]), 32'd1);
    wr(2'd0, 8'hFF);
    cycle();
    chk("t4_irq_restore", 32'(irq_n), 32'd0);
    chk("t4_vec_restore", 32'(vec),   32'd4);
    pulse_ack();
    pulse_eoi();
    src = 8'hFF;
    repeat (3) cycle();

    // Set beats W1C; stray handshakes
    src = 8'hFE;
    cycle(); cycle();
    wr(2'd3, 8'h01);
    chk("t5_set_wins", 32'(rdata[0]), 32'd1);
    cycle();
    chk("t5_req", 32'(irq_n), 32'd0);
    pulse_eoi();
    chk("t5_stray_eoi", 32'(irq_n), 32'd0);
    chk("t5_vec0",      32'(vec),   32'd0);
    pulse_ack();
    chk("t5_svc", 32'(irq_n), 32'd1);
    pulse_eoi();
    pulse_ack();
    chk("t5_stray_ack", 32'(irq_n), 32'd1);
    cycle();
    chk("t5_still_idle", 32'(irq_n), 32'd1);
    src = 8'hFF;
    repeat (3) cycle();

    // Reset during service, then normal operation on source 6
    src = 8'hF7;
    wait_irq();
    pulse_ack();
    chk("t6_svc", 32'(irq_n), 32'd1);
    src = 8'hFF;
    do_reset();
    wr(2'd0, 8'hFF);
    src = 8'hBF;
    wait_irq();
    chk("t6_vec", 32'(vec), 32'd6);
    pulse_ack();
    pulse_eoi();
    src = 8'hFF;
    repeat (3) cycle();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) src = src ^ (8'h01 << $urandom_range(0, N - 1));
      we    = ($urandom_range(0, 9) == 0);
      addr  = 2'($urandom_range(0, 3));
      wdata = 8'($urandom);
      ack   = ($urandom_range(0, 3) == 0);
      eoi   = ($urandom_range(0, 3) == 0);
      cycle();
      if (c == 1500) begin
        src = '1;
        do_reset();
      end
    end
    we = 1'b0; ack = 1'b0; eoi = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
